// File: rtl/peak_meter12.sv
// Purpose : windowed peak-magnitude meter for 12-bit signed samples, with a
//           decaying peak-hold value and a sticky overrun flag.
// Latency : a sample strobed in cycle t updates max/peak/hold/vld at the edge
//           ending t+1, visible in t+2.
// Backpressure: none on the sample side. A result not acked before the next
//           window end is overwritten, and ovr is set.
//
// Ports:
//   clk   - master clock, rising edge
//   rst_n - asynchronous active-low reset
//   sig   - signed 12-bit sample, taken when stb=1
//   stb   - sample strobe
//   win   - window length minus 1, in accepted samples (read live)
//   ack   - reader acknowledge, only honoured while vld=1
//   peak  - peak magnitude of the last completed window
//   hold  - decaying peak-hold value
//   vld   - result pending, from window end until acknowledged
//   ovr   - sticky overrun, cleared by an accepted ack
module peak_meter12 #(
    parameter int unsigned DECAY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] sig,
    input  logic        stb,
    input  logic [15:0] win,
    input  logic        ack,
    output logic [10:0] peak,
    output logic [10:0] hold,
    output logic        vld,
    output logic        ovr
);

    // ------------------------------------------------------------------
    // Stage 1: magnitude register
    // ------------------------------------------------------------------
    logic [10:0] mag_q,    mag_d;
    logic        s1_vld_q, s1_vld_d;
    logic [10:0] mag_now;

    always_comb begin
        mag_now = sig[10:0];
        if (sig[11]) begin
            // -2048 has no positive 11-bit counterpart; clamp it to full scale.
            // For every other negative value, -sig fits in the low 11 bits.
            if (sig[10:0] == 11'd0) begin
                mag_now = 11'h7FF;
            end else begin
                mag_now = ~sig[10:0] + 11'd1;
            end
        end
    end

    always_comb begin
        mag_d    = mag_q;
        s1_vld_d = stb;
        if (stb) begin
            mag_d = mag_now;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: running max, window counter, result and handshake
    // ------------------------------------------------------------------
    logic [10:0] max_q,  max_d;
    logic [15:0] cnt_q,  cnt_d;
    logic [10:0] peak_q, peak_d;
    logic [10:0] hold_q, hold_d;
    logic        vld_q,  vld_d;
    logic        ovr_q,  ovr_d;

    logic [10:0] comb;
    logic [10:0] dec_shift;
    logic [10:0] dec_step;
    logic [10:0] hold_decayed;
    logic        win_end;
    logic        ack_acc;

    always_comb begin
        comb = (mag_q > max_q) ? mag_q : max_q;

        // The hold loses at least 1 LSB per window while nonzero, so it
        // always reaches zero even when hold>>DECAY has rounded to 0.
        // dec_step never exceeds hold_q, so the subtraction cannot wrap.
        dec_shift    = hold_q >> DECAY;
        dec_step     = ((dec_shift == 11'd0) && (hold_q != 11'd0)) ? 11'd1 : dec_shift;
        hold_decayed = hold_q - dec_step;

        // "At or above" so a mid-window reduction of win closes the window
        // on the very next sample instead of waiting for a 16-bit wrap.
        win_end = s1_vld_q && (cnt_q >= win);
        ack_acc = ack && vld_q;
    end

    always_comb begin
        max_d  = max_q;
        cnt_d  = cnt_q;
        peak_d = peak_q;
        hold_d = hold_q;
        vld_d  = vld_q;
        ovr_d  = ovr_q;

        if (s1_vld_q) begin
            if (win_end) begin
                max_d  = 11'd0;
                cnt_d  = 16'd0;
                peak_d = comb;
                hold_d = (comb >= hold_decayed) ? comb : hold_decayed;
            end else begin
                max_d = comb;
                cnt_d = cnt_q + 16'd1;
            end
        end

        if (win_end) begin
            // A fresh result always leaves vld high. It is an overrun only
            // when the previous result is still pending and not being
            // consumed in this same cycle.
            vld_d = 1'b1;
            if (ack_acc) begin
                ovr_d = 1'b0;
            end else if (vld_q) begin
                ovr_d = 1'b1;
            end
        end else if (ack_acc) begin
            vld_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q    <= 11'd0;
            s1_vld_q <= 1'b0;
            max_q    <= 11'd0;
            cnt_q    <= 16'd0;
            peak_q   <= 11'd0;
            hold_q   <= 11'd0;
            vld_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            mag_q    <= mag_d;
            s1_vld_q <= s1_vld_d;
            max_q    <= max_d;
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            hold_q   <= hold_d;
            vld_q    <= vld_d;
            ovr_q    <= ovr_d;
        end
    end

    assign peak = peak_q;
    assign hold = hold_q;
    assign vld  = vld_q;
    assign ovr  = ovr_q;

endmodule

// File: tb/tb_peak_meter12.sv
// Purpose : directed self-checking bench for peak_meter12.
// Latency : inputs change and outputs are sampled 1 ns after each rising edge.
// Backpressure: the bench plays the reader and drives ack explicitly.
module tb_peak_meter12;

    logic        clk;
    logic        rst_n;
    logic [11:0] sig;
    logic        stb;
    logic [15:0] win;
    logic        ack;
    logic [10:0] peak;
    logic [10:0] hold;
    logic        vld;
    logic        ovr;

    int n_checks;
    int n_fail;

    peak_meter12 #(.DECAY(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sig),
        .stb   (stb),
        .win   (win),
        .ack   (ack),
        .peak  (peak),
        .hold  (hold),
        .vld   (vld),
        .ovr   (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stb   = 1'b0;
        ack   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One strobed sample, then one idle clock so it reaches the outputs.
    task automatic one_sample(input logic [11:0] s);
        sig = s;
        stb = 1'b1;
        tick();
        stb = 1'b0;
        tick();
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // Strobe on the first of three clocks.
    task automatic gap_sample(input logic [11:0] s);
        sig = s;
        stb = 1'b1;
        tick();
        stb = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sig      = 12'd0;
        win      = 16'd0;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_peak", int'(peak), 0);
        chk("rst_hold", int'(hold), 0);
        chk("rst_vld",  int'(vld),  0);
        chk("rst_ovr",  int'(ovr),  0);

        // ---------------- window of 4 ----------------
        win = 16'd3;
        stb = 1'b1;
        sig = 12'sd100;  tick();
        sig = -12'sd300; tick();
        sig = 12'sd50;   tick();
        sig = 12'sd7;    tick();
        stb = 1'b0;
        chk("w4_vld_early", int'(vld), 0);
        tick();
        chk("w4_peak", int'(peak), 300);
        chk("w4_hold", int'(hold), 300);
        chk("w4_vld",  int'(vld),  1);
        chk("w4_ovr",  int'(ovr),  0);
        do_ack();
        chk("w4_vld_ack",  int'(vld),  0);
        chk("w4_peak_ack", int'(peak), 300);
        // ack while vld=0 must change nothing
        do_ack();
        chk("idle_ack_vld", int'(vld), 0);
        chk("idle_ack_ovr", int'(ovr), 0);

        // ---------------- saturation ----------------
        win = 16'd0;
        one_sample(12'h800);        // -2048
        chk("sat_peak", int'(peak), 2047);
        chk("sat_hold", int'(hold), 2047);
        do_ack();
        one_sample(12'sd2047);
        chk("pos_fs_peak", int'(peak), 2047);
        do_ack();
        one_sample(12'sd0);
        chk("zero_peak", int'(peak), 0);
        chk("zero_hold", int'(hold), 1920);   // 2047 - 127
        chk("zero_ovr",  int'(ovr),  0);
        do_ack();

        // ---------------- decay ----------------
        do_reset();
        win = 16'd0;
        one_sample(12'sd1600); chk("dec_h0", int'(hold), 1600); do_ack();
        one_sample(12'sd0);    chk("dec_h1", int'(hold), 1500); do_ack();
        chk("dec_peak0", int'(peak), 0);
        one_sample(12'sd0);    chk("dec_h2", int'(hold), 1407); do_ack();
        one_sample(12'sd0);    chk("dec_h3", int'(hold), 1320); do_ack();
        do_reset();
        one_sample(12'sd15);   chk("dec_min_a", int'(hold), 15); do_ack();
        one_sample(12'sd0);    chk("dec_min_b", int'(hold), 14); do_ack();
        do_reset();
        one_sample(12'sd1);    chk("dec_one",   int'(hold), 1);  do_ack();
        one_sample(12'sd0);    chk("dec_zero",  int'(hold), 0);  do_ack();
        one_sample(12'sd0);    chk("dec_stay0", int'(hold), 0);  do_ack();

        // ---------------- overrun and simultaneity ----------------
        do_reset();
        win = 16'd1;
        stb = 1'b1;
        sig = 12'sd10; tick();
        sig = 12'sd20; tick();
        sig = 12'sd30; tick();
        chk("ovr_w0_peak", int'(peak), 20);
        chk("ovr_w0_vld",  int'(vld),  1);
        chk("ovr_w0_ovr",  int'(ovr),  0);
        sig = 12'sd5;  tick();
        stb = 1'b0;
        tick();
        chk("ovr_w1_peak", int'(peak), 30);
        chk("ovr_w1_hold", int'(hold), 30);
        chk("ovr_w1_vld",  int'(vld),  1);
        chk("ovr_w1_ovr",  int'(ovr),  1);
        stb = 1'b1;
        sig = 12'sd7; tick();
        sig = 12'sd9; tick();
        stb = 1'b0;
        ack = 1'b1;                 // coincides with the window end
        tick();
        ack = 1'b0;
        chk("sim_peak", int'(peak), 9);
        chk("sim_hold", int'(hold), 29);
        chk("sim_vld",  int'(vld),  1);
        chk("sim_ovr",  int'(ovr),  0);
        do_ack();
        chk("sim_vld_ack", int'(vld), 0);

        // ---------------- gapped strobes, live win change ----------------
        do_reset();
        win = 16'd7;
        gap_sample(12'sd40);
        gap_sample(-12'sd90);
        gap_sample(12'sd60);
        chk("gap_vld_mid", int'(vld), 0);
        win = 16'd1;
        gap_sample(12'sd25);
        chk("gap_peak", int'(peak), 90);
        chk("gap_vld",  int'(vld),  1);
        do_ack();
        gap_sample(12'sd5);
        chk("gap_restart_vld", int'(vld), 0);
        gap_sample(12'sd8);
        chk("gap_restart_peak", int'(peak), 8);
        chk("gap_restart_ovr",  int'(ovr),  0);
        do_ack();

        // ---------------- async reset mid-operation ----------------
        do_reset();
        win = 16'd0;
        stb = 1'b1;
        sig = 12'sd100; tick();
        sig = 12'sd200; tick();
        stb = 1'b0;
        tick();
        chk("ar_pre_ovr",  int'(ovr),  1);
        chk("ar_pre_peak", int'(peak), 200);
        win = 16'd3;
        sig = 12'sd500;
        stb = 1'b1;
        tick();
        stb = 1'b0;
        #2;                          // between edges
        rst_n = 1'b0;
        #1;
        chk("ar_peak", int'(peak), 0);
        chk("ar_hold", int'(hold), 0);
        chk("ar_vld",  int'(vld),  0);
        chk("ar_ovr",  int'(ovr),  0);
        tick();
        rst_n = 1'b1;
        win = 16'd1;
        stb = 1'b1;
        sig = 12'sd30; tick();
        sig = 12'sd40; tick();
        stb = 1'b0;
        tick();
        chk("ar_post_peak", int'(peak), 40);
        chk("ar_post_hold", int'(hold), 40);
        chk("ar_post_vld",  int'(vld),  1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
